// File: rtl/muldiv_unit_pkg.sv
// Shared decode codes, FSM state encoding and op-class helpers for the
// multiply/divide unit. The ALU_OP_* values mirror the control block's
// op encoding so the decode stage can forward its alu_op field unchanged.
package muldiv_unit_pkg;

  localparam logic [5:0] ALU_OP_MUL  = 6'h18;
  localparam logic [5:0] ALU_OP_MUH  = 6'h19;
  localparam logic [5:0] ALU_OP_MULU = 6'h1A;
  localparam logic [5:0] ALU_OP_MUHU = 6'h1B;
  localparam logic [5:0] ALU_OP_DIV  = 6'h1C;
  localparam logic [5:0] ALU_OP_MOD  = 6'h1D;
  localparam logic [5:0] ALU_OP_DIVU = 6'h1E;
  localparam logic [5:0] ALU_OP_MODU = 6'h1F;
  localparam logic [5:0] ALU_OP_ADD  = 6'h20;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input logic [5:0] op);
    return op inside {ALU_OP_MUL, ALU_OP_MUH, ALU_OP_MULU, ALU_OP_MUHU,
                      ALU_OP_DIV, ALU_OP_MOD, ALU_OP_DIVU, ALU_OP_MODU};
  endfunction

  function automatic logic op_is_signed(input logic [5:0] op);
    return op inside {ALU_OP_MUL, ALU_OP_MUH, ALU_OP_DIV, ALU_OP_MOD};
  endfunction

  function automatic logic op_is_div(input logic [5:0] op);
    return op inside {ALU_OP_DIV, ALU_OP_MOD, ALU_OP_DIVU, ALU_OP_MODU};
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-divide step: shift a dividend bit into the partial remainder
// and trial-subtract the divisor. Purely combinational, zero latency, no flow control.
// Ports: rem_in/dividend_bit/divisor in; rem_out/q_bit out.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    trial = {rem_in, dividend_bit};
    q_bit = (trial >= {1'b0, divisor});
    // When the subtraction succeeds the true difference always fits in WIDTH
    // bits (or the divisor is zero and it equals the trial value), so the
    // modular low-word subtract is exact.
    diff    = trial[WIDTH-1:0] - divisor;
    rem_out = q_bit ? diff : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (MUL/MUH/MULU/MUHU/DIV/MOD/DIVU/MODU).
// Latency: done pulses WIDTH+1 edges after the accepting edge; busy covers CALC and DONE.
// Backpressure: start is only sampled in IDLE; cancel aborts without a done pulse.
// Ports: clk, rst_n (sync, active-low), start, cancel, alu_op, src_a, src_b in;
//        busy, done, result (held until the next completed op) out.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Counter runs 0..WIDTH-1 for iterations, WIDTH is the result-load cycle.
  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        state_q, state_d;
  logic [5:0]       op_q;
  logic             sign_a_q, sign_b_q;
  logic [WIDTH-1:0] mag_a_q, mag_b_q;
  // sh_q: multiplier shifted out LSB-first, or dividend shifted out MSB-first
  // while the quotient shifts in behind it.
  logic [WIDTH-1:0]   sh_q;
  // acc_q: {hi, lo} product for multiply; low word is the remainder for divide.
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;

  logic             accept, last;
  logic             in_signed, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fin_res, raw_a;

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc_q[WIDTH-1:0]),
    .dividend_bit (sh_q[WIDTH-1]),
    .divisor      (mag_b_q),
    .rem_out      (rem_nxt),
    .q_bit        (q_bit)
  );

  always_comb begin
    accept    = (state_q == MD_ST_IDLE) && start && !cancel && is_md_op(alu_op);
    last      = (cnt_q == CW'(WIDTH));
    in_signed = op_is_signed(alu_op);
    neg_a     = in_signed && src_a[WIDTH-1];
    neg_b     = in_signed && src_b[WIDTH-1];
    abs_a     = neg_a ? -src_a : src_a;
    abs_b     = neg_b ? -src_b : src_b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (sh_q[0] ? {1'b0, mag_a_q} : '0);
  end

  // Final result from the completed magnitudes.
  always_comb begin
    fin_res = '0;
    prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    raw_a   = sign_a_q ? -mag_a_q : mag_a_q;
    case (op_q)
      ALU_OP_MUL, ALU_OP_MULU: fin_res = prod[WIDTH-1:0];
      ALU_OP_MUH, ALU_OP_MUHU: fin_res = prod[2*WIDTH-1:WIDTH];
      ALU_OP_DIV, ALU_OP_DIVU:
        fin_res = (mag_b_q == '0) ? '1 :
                  ((sign_a_q ^ sign_b_q) ? -sh_q : sh_q);
      ALU_OP_MOD, ALU_OP_MODU:
        fin_res = (mag_b_q == '0) ? raw_a :
                  (sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      default: fin_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      MD_ST_IDLE: if (accept) state_d = MD_ST_CALC;
      MD_ST_CALC: begin
        busy = 1'b1;
        if (cancel)    state_d = MD_ST_IDLE;
        else if (last) state_d = MD_ST_DONE;
      end
      MD_ST_DONE: begin
        busy    = 1'b1;
        done    = !cancel;
        state_d = MD_ST_IDLE;
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MD_ST_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= alu_op;
        sign_a_q <= neg_a;
        sign_b_q <= neg_b;
        mag_a_q  <= abs_a;
        mag_b_q  <= abs_b;
        sh_q     <= op_is_div(alu_op) ? abs_a : abs_b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == MD_ST_CALC && !cancel) begin
        if (!last) begin
          cnt_q <= cnt_q + CW'(1);
          if (op_is_div(op_q)) begin
            acc_q <= {acc_q[2*WIDTH-1:WIDTH], rem_nxt};
            sh_q  <= {sh_q[WIDTH-2:0], q_bit};
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            sh_q  <= sh_q >> 1;
          end
        end else begin
          result_q <= fin_res;
        end
      end
    end
  end

  assign result = result_q;

endmodule
